// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl_if
//  Brief    : Handshake/status bundle between the pong game sequencer and the
//             ball datapath / display logic.
//  Revision : 1.0  initial release
// ============================================================================
interface pong_game_ctrl_if #(
  parameter int LIVES_W = 3
);
  logic               start_btn;
  logic               pause_btn;
  logic               miss_left;
  logic               miss_right;
  logic               paddle_hit;
  logic               ball_tick_en;
  logic               ball_center;
  logic               serve_dir;
  logic [LIVES_W-1:0] lives_l;
  logic [LIVES_W-1:0] lives_r;
  logic               game_over;
  logic               winner;
  logic [1:0]         state;

  // Sequencer side
  modport master (
    input  start_btn, pause_btn, miss_left, miss_right, paddle_hit,
    output ball_tick_en, ball_center, serve_dir, lives_l, lives_r,
           game_over, winner, state
  );

  // Datapath / button / display side
  modport slave (
    output start_btn, pause_btn, miss_left, miss_right, paddle_hit,
    input  ball_tick_en, ball_center, serve_dir, lives_l, lives_r,
           game_over, winner, state
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Brief    : Pong match sequencer: match FSM, lives counters, ball step
//             divider. Optional macro SPEEDUP_EN enables paddle-hit speed-up.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int TICK_DIV    = 65536,
  parameter int SERVE_TICKS = 60,
  parameter int LIVES       = 7,
  parameter int LIVES_W     = 3
) (
  input logic              clk,
  input logic              rst,
  pong_game_ctrl_if.master bus
);
  localparam int                 DIV_W      = $clog2(TICK_DIV + 1);
  localparam int                 SRV_W      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [DIV_W-1:0]   DIV_BASE   = DIV_W'(TICK_DIV);
  localparam logic [SRV_W-1:0]   SRV_LAST   = SRV_W'(SERVE_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div;
  logic [SRV_W-1:0]   srv_cnt_q, srv_cnt_d;
  logic [LIVES_W-1:0] lives_l_q, lives_l_d, lives_r_q, lives_r_d;
  logic               start_prev_q, start_prev_d, start_edge_q, start_edge_d;
  logic               pause_prev_q, pause_prev_d, pause_edge_q, pause_edge_d;
  logic               paused_q, paused_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               ball_tick_en_q, ball_tick_en_d;
  logic               ball_center_q, ball_center_d;
  logic               game_over_q, game_over_d;
  logic               running, tick;

`ifdef SPEEDUP_EN
  logic [1:0] hit_cnt_q, hit_cnt_d, lvl_q, lvl_d;

  // Every fourth hit in PLAY raises the speed level, capped at 2.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    lvl_d     = lvl_q;
    if (state_q == ST_PLAY && bus.paddle_hit) begin
      hit_cnt_d = hit_cnt_q + 2'd1;
      if (hit_cnt_q == 2'd3 && lvl_q != 2'd2) lvl_d = lvl_q + 2'd1;
    end
    if (state_d == ST_SERVE && state_q != ST_SERVE) begin
      hit_cnt_d = 2'd0;
      lvl_d     = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= 2'd0;
      lvl_q     <= 2'd0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      lvl_q     <= lvl_d;
    end
  end

  assign div = DIV_BASE >> lvl_q;
`else
  logic unused_paddle_hit;
  assign unused_paddle_hit = bus.paddle_hit;
  assign div               = DIV_BASE;
`endif

  always_comb begin
    state_d      = state_q;
    srv_cnt_d    = srv_cnt_q;
    lives_l_d    = lives_l_q;
    lives_r_d    = lives_r_q;
    paused_d     = paused_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    start_prev_d = bus.start_btn;
    start_edge_d = bus.start_btn & ~start_prev_q;
    pause_prev_d = bus.pause_btn;
    pause_edge_d = bus.pause_btn & ~pause_prev_q;

    // '>=' keeps the wrap safe when a speed-up shrinks div below the count.
    running = (state_q == ST_SERVE) || (state_q == ST_PLAY && !paused_q);
    tick    = running && (cnt_q >= div - DIV_W'(1));
    cnt_d   = cnt_q;
    if (running) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge_q) begin
          state_d     = ST_SERVE;
          lives_l_d   = LIVES_INIT;
          lives_r_d   = LIVES_INIT;
          serve_dir_d = 1'b0;
          winner_d    = 1'b0;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (srv_cnt_q == SRV_LAST) state_d = ST_PLAY;
          else                       srv_cnt_d = srv_cnt_q + SRV_W'(1);
        end
      end
      ST_PLAY: begin
        if (pause_edge_q) paused_d = ~paused_q;
        if (!paused_q) begin
          if (bus.miss_left) begin
            lives_l_d   = (lives_l_q != '0) ? lives_l_q - LIVES_W'(1) : '0;
            serve_dir_d = 1'b1;
            if (lives_l_q <= LIVES_W'(1)) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
            end else begin
              state_d  = ST_SERVE;
            end
          end else if (bus.miss_right) begin
            lives_r_d   = (lives_r_q != '0) ? lives_r_q - LIVES_W'(1) : '0;
            serve_dir_d = 1'b0;
            if (lives_r_q <= LIVES_W'(1)) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
            end else begin
              state_d  = ST_SERVE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d     = '0;
      srv_cnt_d = '0;
      paused_d  = 1'b0;
    end

    // A step is suppressed on the clock that leaves PLAY.
    ball_tick_en_d = tick && (state_q == ST_PLAY) && (state_d == ST_PLAY);
    ball_center_d  = (state_d != ST_PLAY);
    game_over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      srv_cnt_q      <= '0;
      lives_l_q      <= LIVES_INIT;
      lives_r_q      <= LIVES_INIT;
      start_prev_q   <= 1'b0;
      start_edge_q   <= 1'b0;
      pause_prev_q   <= 1'b0;
      pause_edge_q   <= 1'b0;
      paused_q       <= 1'b0;
      serve_dir_q    <= 1'b0;
      winner_q       <= 1'b0;
      ball_tick_en_q <= 1'b0;
      ball_center_q  <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      srv_cnt_q      <= srv_cnt_d;
      lives_l_q      <= lives_l_d;
      lives_r_q      <= lives_r_d;
      start_prev_q   <= start_prev_d;
      start_edge_q   <= start_edge_d;
      pause_prev_q   <= pause_prev_d;
      pause_edge_q   <= pause_edge_d;
      paused_q       <= paused_d;
      serve_dir_q    <= serve_dir_d;
      winner_q       <= winner_d;
      ball_tick_en_q <= ball_tick_en_d;
      ball_center_q  <= ball_center_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.lives_l      = lives_l_q;
  assign bus.lives_r      = lives_r_q;
  assign bus.ball_tick_en = ball_tick_en_q;
  assign bus.ball_center  = ball_center_q;
  assign bus.serve_dir    = serve_dir_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;
endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Brief    : Self-checking bench for pong_game_ctrl with randomized timing
//             against a scenario-level game model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 3;
  localparam int LIVES       = 2;
  localparam int LIVES_W     = 3;
  localparam int SERVE_CLK   = TICK_DIV * SERVE_TICKS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Game model: lives, serve direction, winner
  int   exp_ll = LIVES;
  int   exp_lr = LIVES;
  bit   exp_dir = 1'b0;

  pong_game_ctrl_if #(.LIVES_W(LIVES_W)) bus ();

  pong_game_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .SERVE_TICKS(SERVE_TICKS),
    .LIVES      (LIVES),
    .LIVES_W    (LIVES_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] obs();
    return {bus.state, bus.lives_l, bus.lives_r, bus.ball_tick_en,
            bus.ball_center, bus.serve_dir, bus.game_over, bus.winner};
  endfunction

  function automatic logic [12:0] expv(int st, int ll, int lr, bit ten,
                                       bit ctr, bit dir, bit go, bit win);
    return {2'(st), 3'(ll), 3'(lr), ten, ctr, dir, go, win};
  endfunction

  task automatic pulse_miss(input bit l, input bit r);
    bus.miss_left  = l;
    bus.miss_right = r;
    clk1();
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    clk1();
    clk1();
    bus.start_btn = 1'b0;
  endtask

  task automatic wait_play(output int n);
    n = 0;
    while (bus.state !== 2'd2 && n < 40) begin
      clk1();
      n++;
    end
    checks++;
    if (n != SERVE_CLK) begin
      errors++;
      $display("FAIL serve_len: got %0d clk want %0d clk (state=%0d)", n, SERVE_CLK, bus.state);
    end
  endtask

  task automatic test_reset();
    logic [12:0] e;
    bus.start_btn = 0; bus.pause_btn = 0; bus.miss_left = 0;
    bus.miss_right = 0; bus.paddle_hit = 0;
    rst = 1'b1;
    clk1(); clk1();
    e = expv(0, LIVES, LIVES, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset: got %b want %b", obs(), e);
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    logic [12:0] e;
    int hold = $urandom_range(2, 10);
    int n    = $urandom_range(8, 20);
    int st;
    bus.start_btn = 1'b1;
    for (int i = 1; i <= 2 + SERVE_CLK; i++) begin
      clk1();
      if (i == hold) bus.start_btn = 1'b0;
      st = (i < 2) ? 0 : (i < 2 + SERVE_CLK) ? 1 : 2;
      e  = expv(st, LIVES, LIVES, 0, st != 2, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL start_seq c%0d: got %b want %b", i, obs(), e);
      end
    end
    for (int p = 1; p <= n; p++) begin
      clk1();
      e = expv(2, LIVES, LIVES, (p % TICK_DIV) == 0, 0, 0, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL play_ticks p%0d: got %b want %b", p, obs(), e);
      end
    end
  endtask

  task automatic test_miss();
    logic [12:0] e;
    bit side = 1'($urandom_range(0, 1));
    bit over;
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) wait_play(n);
      repeat ($urandom_range(0, 7)) clk1();
      pulse_miss(side, !side);
      if (side) begin exp_ll--; exp_dir = 1'b1; end
      else      begin exp_lr--; exp_dir = 1'b0; end
      over = (exp_ll == 0) || (exp_lr == 0);
      e = expv(over ? 3 : 1, exp_ll, exp_lr, 0, 1, exp_dir, over, over ? side : 1'b0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL miss_%0d side%0d: got %b want %b", k, side, obs(), e);
      end
    end
    pulse_miss(!side, side);
    e = expv(3, exp_ll, exp_lr, 0, 1, exp_dir, 1, side);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL over_frozen: got %b want %b", obs(), e);
    end
    bus.start_btn = 1'b1;
    clk1();
    checks++;
    if (bus.state !== 2'd3) begin
      errors++; $display("FAIL restart_latency: got state %0d want 3", bus.state);
    end
    clk1();
    bus.start_btn = 1'b0;
    exp_ll = LIVES; exp_lr = LIVES; exp_dir = 1'b0;
    e = expv(1, LIVES, LIVES, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL restart: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] e;
    int n;
    wait_play(n);
    repeat ($urandom_range(0, 6)) clk1();
    pulse_miss(1'b1, 1'b1);
    exp_ll--; exp_dir = 1'b1;
    e = expv(1, exp_ll, exp_lr, 0, 1, exp_dir, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL both_miss: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_pause();
    logic [12:0] e;
    int  n, phase = 0;
    int  run   = $urandom_range(1, 9);
    int  hold  = $urandom_range(3, 8);
    int  hold2 = $urandom_range(2, 6);
    int  ml    = $urandom_range(5, 45);
    int  mr    = $urandom_range(5, 45);
    bit  act;
    wait_play(n);
    for (int c = 1; c <= run; c++) begin
      clk1(); phase++;
      e = expv(2, exp_ll, exp_lr, (phase % TICK_DIV) == 0, 0, exp_dir, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL pre_pause c%0d: got %b want %b", c, obs(), e);
      end
    end
    bus.pause_btn = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      bus.miss_left  = (c == ml);
      bus.miss_right = (c == mr);
      clk1();
      if (c == hold) bus.pause_btn = 1'b0;
      act = (c <= 2);
      if (act) phase++;
      e = expv(2, exp_ll, exp_lr, act && (phase % TICK_DIV) == 0, 0, exp_dir, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL paused c%0d: got %b want %b", c, obs(), e);
      end
    end
    bus.miss_left = 1'b0; bus.miss_right = 1'b0;
    bus.pause_btn = 1'b1;
    for (int c = 1; c <= 4 * TICK_DIV + 2; c++) begin
      clk1();
      if (c == hold2) bus.pause_btn = 1'b0;
      act = (c > 2);
      if (act) phase++;
      e = expv(2, exp_ll, exp_lr, act && (phase % TICK_DIV) == 0, 0, exp_dir, 0, 0);
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL resume c%0d: got %b want %b", c, obs(), e);
      end
    end
    bus.pause_btn = 1'b0;
    pulse_miss(1'b1, 1'b0);
    exp_ll--; exp_dir = 1'b1;
    e = expv(3, exp_ll, exp_lr, 0, 1, 1, 1, 1);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL final_miss: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    int n;
    press_start();
    exp_ll = LIVES; exp_lr = LIVES; exp_dir = 1'b0;
    wait_play(n);
    pulse_miss(1'b1, 1'b0);
    wait_play(n);
    pulse_miss(1'b0, 1'b1);
    e = expv(1, 1, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL lives_1_1: got %b want %b", obs(), e);
    end
    wait_play(n);
    repeat ($urandom_range(0, 6)) clk1();
    rst = 1'b1;
    bus.miss_left = 1'b1;
    clk1();
    rst = 1'b0;
    bus.miss_left = 1'b0;
    exp_ll = LIVES; exp_lr = LIVES; exp_dir = 1'b0;
    e = expv(0, LIVES, LIVES, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL mid_reset: got %b want %b", obs(), e);
    end
    repeat (5) clk1();
    checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", obs(), e);
    end
  endtask

`ifdef SPEEDUP_EN
  task automatic measure_gap(output int gap);
    int w = 0;
    while (bus.ball_tick_en !== 1'b1 && w < 20) begin clk1(); w++; end
    gap = 0;
    do begin clk1(); gap++; end while (bus.ball_tick_en !== 1'b1 && gap < 20);
  endtask

  task automatic hits(input int k);
    for (int i = 0; i < k; i++) begin
      bus.paddle_hit = 1'b1; clk1();
    end
    bus.paddle_hit = 1'b0;
  endtask

  task automatic test_speedup();
    int n, gap;
    press_start();
    wait_play(n);
    hits(4);
    measure_gap(gap);
    checks++;
    if (gap != TICK_DIV / 2) begin
      errors++; $display("FAIL speed_lvl1: got gap %0d want %0d", gap, TICK_DIV / 2);
    end
    hits(8);
    measure_gap(gap);
    checks++;
    if (gap != TICK_DIV / 4) begin
      errors++; $display("FAIL speed_lvl2: got gap %0d want %0d", gap, TICK_DIV / 4);
    end
    pulse_miss(1'b0, 1'b1);
    wait_play(n);
    measure_gap(gap);
    checks++;
    if (gap != TICK_DIV) begin
      errors++; $display("FAIL speed_cleared: got gap %0d want %0d", gap, TICK_DIV);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_miss();
    test_simultaneous();
    test_pause();
    test_reset_mid();
`ifdef SPEEDUP_EN
    test_speedup();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
